// File: rtl/rgb_line_reader.sv
// Read-side controller for the RGB line buffers: walks a 12.12 source coordinate per output
// pixel, drives both banks' even/odd read addresses and aligns the returned 2x2 neighbourhood.
module rgb_line_reader #(
  parameter int unsigned C_ADDR_WIDTH = 12,
  parameter int unsigned C_FRAC_WIDTH = 12
) (
  input  logic                    clk,
  input  logic                    rst,

  input  logic                    start,
  input  logic [C_ADDR_WIDTH-1:0] src_width,
  input  logic [C_ADDR_WIDTH-1:0] dst_width,
  input  logic [15:0]             step,
  input  logic                    row_sel,

  output logic [C_ADDR_WIDTH-1:0] even_bram1_raddr,
  output logic [C_ADDR_WIDTH-1:0] odd_bram1_raddr,
  output logic [C_ADDR_WIDTH-1:0] even_bram2_raddr,
  output logic [C_ADDR_WIDTH-1:0] odd_bram2_raddr,

  input  logic [7:0]              even_bram1_r_rdata,
  input  logic [7:0]              even_bram1_g_rdata,
  input  logic [7:0]              even_bram1_b_rdata,
  input  logic [7:0]              odd_bram1_r_rdata,
  input  logic [7:0]              odd_bram1_g_rdata,
  input  logic [7:0]              odd_bram1_b_rdata,
  input  logic [7:0]              even_bram2_r_rdata,
  input  logic [7:0]              even_bram2_g_rdata,
  input  logic [7:0]              even_bram2_b_rdata,
  input  logic [7:0]              odd_bram2_r_rdata,
  input  logic [7:0]              odd_bram2_g_rdata,
  input  logic [7:0]              odd_bram2_b_rdata,

  output logic                    busy,
  output logic                    out_valid,
  output logic [23:0]             pix_tl,
  output logic [23:0]             pix_tr,
  output logic [23:0]             pix_bl,
  output logic [23:0]             pix_br,
  output logic [7:0]              frac_x,
  output logic                    done
);

  localparam int unsigned AccW = C_ADDR_WIDTH + C_FRAC_WIDTH;

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StRun   = 2'd1;
  localparam logic [1:0] StFlush = 2'd2;

  localparam logic [C_ADDR_WIDTH-1:0] AddrOne = {{(C_ADDR_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [C_ADDR_WIDTH:0]   IncOne  = {{C_ADDR_WIDTH{1'b0}}, 1'b1};

  // Control state
  logic [1:0]              state_q, state_d;
  logic [C_ADDR_WIDTH-1:0] src_w_q, src_w_d;
  logic [C_ADDR_WIDTH-1:0] dst_w_q, dst_w_d;
  logic [15:0]             step_q, step_d;
  logic                    row_sel_q, row_sel_d;
  logic [AccW-1:0]         acc_q, acc_d;
  logic [C_ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic [1:0]              flush_cnt_q, flush_cnt_d;

  // Sideband pipeline and output registers
  logic                    s1_valid_q, s1_valid_d;
  logic [7:0]              s1_frac_q, s1_frac_d;
  logic                    out_valid_q, out_valid_d;
  logic [7:0]              frac_x_q, frac_x_d;
  logic [23:0]             pix_tl_q, pix_tl_d;
  logic [23:0]             pix_tr_q, pix_tr_d;
  logic [23:0]             pix_bl_q, pix_bl_d;
  logic [23:0]             pix_br_q, pix_br_d;

  // Address generation
  logic                    issue;
  logic [C_ADDR_WIDTH-1:0] src_max;
  logic [C_ADDR_WIDTH-1:0] acc_int;
  logic [C_ADDR_WIDTH-1:0] x0;
  logic [C_ADDR_WIDTH:0]   x1_inc;
  logic [C_ADDR_WIDTH-1:0] x1;
  logic [AccW-1:0]         step_ext;
  logic [7:0]              acc_frac;

  always_comb begin
    issue    = (state_q == StRun);
    src_max  = src_w_q - AddrOne;
    acc_int  = acc_q[AccW-1 -: C_ADDR_WIDTH];
    x0       = (acc_int > src_max) ? src_max : acc_int;
    x1_inc   = {1'b0, x0} + IncOne;
    x1       = (x1_inc > {1'b0, src_max}) ? src_max : x1_inc[C_ADDR_WIDTH-1:0];
    step_ext = {{(AccW-16){1'b0}}, step_q};
    acc_frac = acc_q[C_FRAC_WIDTH-1 -: 8];
  end

  // Addresses are only driven while issuing; otherwise the buses rest at zero.
  assign even_bram1_raddr = issue ? x0 : '0;
  assign even_bram2_raddr = issue ? x0 : '0;
  assign odd_bram1_raddr  = issue ? x1 : '0;
  assign odd_bram2_raddr  = issue ? x1 : '0;

  always_comb begin
    state_d     = state_q;
    src_w_d     = src_w_q;
    dst_w_d     = dst_w_q;
    step_d      = step_q;
    row_sel_d   = row_sel_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    flush_cnt_d = flush_cnt_q;

    case (state_q)
      StIdle: begin
        if (start) begin
          src_w_d     = src_width;
          dst_w_d     = dst_width;
          step_d      = step;
          row_sel_d   = row_sel;
          acc_d       = '0;
          cnt_d       = '0;
          flush_cnt_d = 2'd0;
          state_d     = (dst_width == '0) ? StFlush : StRun;
        end
      end
      StRun: begin
        acc_d = acc_q + step_ext;
        cnt_d = cnt_q + AddrOne;
        if (cnt_q == dst_w_q - AddrOne) begin
          state_d     = StFlush;
          flush_cnt_d = 2'd0;
        end
      end
      StFlush: begin
        // Two drain cycles for the bank read and output register, then the done cycle.
        if (flush_cnt_q == 2'd2) begin
          state_d = StIdle;
        end else begin
          flush_cnt_d = flush_cnt_q + 2'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  logic [23:0] even1_rgb, odd1_rgb, even2_rgb, odd2_rgb;

  always_comb begin
    even1_rgb = {even_bram1_r_rdata, even_bram1_g_rdata, even_bram1_b_rdata};
    odd1_rgb  = {odd_bram1_r_rdata, odd_bram1_g_rdata, odd_bram1_b_rdata};
    even2_rgb = {even_bram2_r_rdata, even_bram2_g_rdata, even_bram2_b_rdata};
    odd2_rgb  = {odd_bram2_r_rdata, odd_bram2_g_rdata, odd_bram2_b_rdata};
  end

  always_comb begin
    s1_valid_d  = issue;
    s1_frac_d   = issue ? acc_frac : s1_frac_q;
    out_valid_d = s1_valid_q;
    frac_x_d    = frac_x_q;
    pix_tl_d    = pix_tl_q;
    pix_tr_d    = pix_tr_q;
    pix_bl_d    = pix_bl_q;
    pix_br_d    = pix_br_q;

    if (s1_valid_q) begin
      frac_x_d = s1_frac_q;
      if (row_sel_q) begin
        pix_tl_d = even2_rgb;
        pix_tr_d = odd2_rgb;
        pix_bl_d = even1_rgb;
        pix_br_d = odd1_rgb;
      end else begin
        pix_tl_d = even1_rgb;
        pix_tr_d = odd1_rgb;
        pix_bl_d = even2_rgb;
        pix_br_d = odd2_rgb;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      src_w_q     <= '0;
      dst_w_q     <= '0;
      step_q      <= '0;
      row_sel_q   <= 1'b0;
      acc_q       <= '0;
      cnt_q       <= '0;
      flush_cnt_q <= 2'd0;
      s1_valid_q  <= 1'b0;
      s1_frac_q   <= '0;
      out_valid_q <= 1'b0;
      frac_x_q    <= '0;
      pix_tl_q    <= '0;
      pix_tr_q    <= '0;
      pix_bl_q    <= '0;
      pix_br_q    <= '0;
    end else begin
      state_q     <= state_d;
      src_w_q     <= src_w_d;
      dst_w_q     <= dst_w_d;
      step_q      <= step_d;
      row_sel_q   <= row_sel_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      flush_cnt_q <= flush_cnt_d;
      s1_valid_q  <= s1_valid_d;
      s1_frac_q   <= s1_frac_d;
      out_valid_q <= out_valid_d;
      frac_x_q    <= frac_x_d;
      pix_tl_q    <= pix_tl_d;
      pix_tr_q    <= pix_tr_d;
      pix_bl_q    <= pix_bl_d;
      pix_br_q    <= pix_br_d;
    end
  end

  assign busy      = (state_q != StIdle);
  assign done      = (state_q == StFlush) && (flush_cnt_q == 2'd2);
  assign out_valid = out_valid_q;
  assign frac_x    = frac_x_q;
  assign pix_tl    = pix_tl_q;
  assign pix_tr    = pix_tr_q;
  assign pix_bl    = pix_bl_q;
  assign pix_br    = pix_br_q;

endmodule

// File: tb/tb_rgb_line_reader.sv
// Randomized bench for rgb_line_reader: a 1-cycle-latency bank model plus a per-pixel
// reference computed directly from coordinate = i * step.
module tb_rgb_line_reader;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [11:0] src_width, dst_width;
  logic [15:0] step;
  logic        row_sel;
  logic [11:0] even_bram1_raddr, odd_bram1_raddr, even_bram2_raddr, odd_bram2_raddr;
  logic [7:0]  even_bram1_r_rdata, even_bram1_g_rdata, even_bram1_b_rdata;
  logic [7:0]  odd_bram1_r_rdata, odd_bram1_g_rdata, odd_bram1_b_rdata;
  logic [7:0]  even_bram2_r_rdata, even_bram2_g_rdata, even_bram2_b_rdata;
  logic [7:0]  odd_bram2_r_rdata, odd_bram2_g_rdata, odd_bram2_b_rdata;
  logic        busy, out_valid, done;
  logic [23:0] pix_tl, pix_tr, pix_bl, pix_br;
  logic [7:0]  frac_x;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [23:0] key1, key2;

  always #5 clk = ~clk;

  rgb_line_reader #(.C_ADDR_WIDTH(12), .C_FRAC_WIDTH(12)) dut (
    .clk(clk), .rst(rst), .start(start), .src_width(src_width), .dst_width(dst_width),
    .step(step), .row_sel(row_sel),
    .even_bram1_raddr(even_bram1_raddr), .odd_bram1_raddr(odd_bram1_raddr),
    .even_bram2_raddr(even_bram2_raddr), .odd_bram2_raddr(odd_bram2_raddr),
    .even_bram1_r_rdata(even_bram1_r_rdata), .even_bram1_g_rdata(even_bram1_g_rdata),
    .even_bram1_b_rdata(even_bram1_b_rdata),
    .odd_bram1_r_rdata(odd_bram1_r_rdata), .odd_bram1_g_rdata(odd_bram1_g_rdata),
    .odd_bram1_b_rdata(odd_bram1_b_rdata),
    .even_bram2_r_rdata(even_bram2_r_rdata), .even_bram2_g_rdata(even_bram2_g_rdata),
    .even_bram2_b_rdata(even_bram2_b_rdata),
    .odd_bram2_r_rdata(odd_bram2_r_rdata), .odd_bram2_g_rdata(odd_bram2_g_rdata),
    .odd_bram2_b_rdata(odd_bram2_b_rdata),
    .busy(busy), .out_valid(out_valid),
    .pix_tl(pix_tl), .pix_tr(pix_tr), .pix_bl(pix_bl), .pix_br(pix_br),
    .frac_x(frac_x), .done(done)
  );

  // Line-buffer contents: a distinct, address-dependent word per bank.
  function automatic logic [23:0] bank_word(input int b, input logic [11:0] a);
    logic [23:0] k;
    logic [7:0]  lo;
    k  = (b == 1) ? key1 : key2;
    lo = a[7:0] + 8'h5a;
    return {a[7:0], a[11:4], lo} ^ k;
  endfunction

  function automatic logic [7:0] bank_byte(input int b, input logic [11:0] a, input int ch);
    logic [23:0] w;
    w = bank_word(b, a);
    if (ch == 0) return w[23:16];
    if (ch == 1) return w[15:8];
    return w[7:0];
  endfunction

  always @(posedge clk) begin
    even_bram1_r_rdata <= bank_byte(1, even_bram1_raddr, 0);
    even_bram1_g_rdata <= bank_byte(1, even_bram1_raddr, 1);
    even_bram1_b_rdata <= bank_byte(1, even_bram1_raddr, 2);
    odd_bram1_r_rdata  <= bank_byte(1, odd_bram1_raddr, 0);
    odd_bram1_g_rdata  <= bank_byte(1, odd_bram1_raddr, 1);
    odd_bram1_b_rdata  <= bank_byte(1, odd_bram1_raddr, 2);
    even_bram2_r_rdata <= bank_byte(2, even_bram2_raddr, 0);
    even_bram2_g_rdata <= bank_byte(2, even_bram2_raddr, 1);
    even_bram2_b_rdata <= bank_byte(2, even_bram2_raddr, 2);
    odd_bram2_r_rdata  <= bank_byte(2, odd_bram2_raddr, 0);
    odd_bram2_g_rdata  <= bank_byte(2, odd_bram2_raddr, 1);
    odd_bram2_b_rdata  <= bank_byte(2, odd_bram2_raddr, 2);
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference pixel i of a line: source coordinate is simply i*step modulo the 24-bit range.
  task automatic ref_pix(input int i, input int src, input logic [15:0] stp, input logic rs,
                         output logic [11:0] x0, output logic [11:0] x1, output logic [7:0] fr,
                         output logic [23:0] tl, output logic [23:0] tr,
                         output logic [23:0] bl, output logic [23:0] br);
    longint coord;
    int     ix, top, bot;
    coord = (longint'(i) * longint'(stp)) % (longint'(1) << 24);
    ix    = int'(coord >> 12);
    fr    = 8'((coord >> 4) & 255);
    x0    = 12'((ix > src - 1) ? src - 1 : ix);
    x1    = 12'((int'(x0) + 1 > src - 1) ? src - 1 : int'(x0) + 1);
    top   = rs ? 2 : 1;
    bot   = rs ? 1 : 2;
    tl    = bank_word(top, x0);
    tr    = bank_word(top, x1);
    bl    = bank_word(bot, x0);
    br    = bank_word(bot, x1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_busy"}, 32'(busy), 0);
    check_eq({tag, "_valid"}, 32'(out_valid), 0);
    check_eq({tag, "_done"}, 32'(done), 0);
    check_eq({tag, "_pix"}, 32'(pix_tl | pix_tr | pix_bl | pix_br), 0);
    check_eq({tag, "_frac"}, 32'(frac_x), 0);
    check_eq({tag, "_raddr"},
             32'(even_bram1_raddr | odd_bram1_raddr | even_bram2_raddr | odd_bram2_raddr), 0);
  endtask

  task automatic run_line(input int src, input int dst, input logic [15:0] stp,
                          input logic rs, input bit restart);
    logic [11:0] x0, x1;
    logic [7:0]  fr;
    logic [23:0] tl, tr, bl, br;
    @(negedge clk);
    key1      = 24'($urandom);
    key2      = 24'($urandom);
    src_width = 12'(src);
    dst_width = 12'(dst);
    step      = stp;
    row_sel   = rs;
    start     = 1'b1;
    for (int k = 1; k <= dst + 5; k++) begin
      @(negedge clk);
      start = (restart && k == 2);
      if (k == 1) begin
        // Scramble the start-sampled inputs to prove they were latched.
        src_width = 12'($urandom);
        dst_width = 12'($urandom);
        step      = 16'($urandom);
        row_sel   = 1'($urandom);
      end
      check_eq("busy", 32'(busy), 32'(k <= dst + 3));
      check_eq("done", 32'(done), 32'(k == dst + 3));
      check_eq("out_valid", 32'(out_valid), 32'(k >= 3 && k <= dst + 2));
      if (k <= dst) begin
        ref_pix(k - 1, src, stp, rs, x0, x1, fr, tl, tr, bl, br);
        check_eq("even1_raddr", 32'(even_bram1_raddr), 32'(x0));
        check_eq("odd1_raddr", 32'(odd_bram1_raddr), 32'(x1));
        check_eq("even2_raddr", 32'(even_bram2_raddr), 32'(x0));
        check_eq("odd2_raddr", 32'(odd_bram2_raddr), 32'(x1));
      end
      if ((k >= 3 && k <= dst + 2) || (dst > 0 && k == dst + 3)) begin
        // In the done cycle the outputs must still hold the last pixel.
        ref_pix((k <= dst + 2) ? k - 3 : dst - 1, src, stp, rs, x0, x1, fr, tl, tr, bl, br);
        check_eq("pix_tl", 32'(pix_tl), 32'(tl));
        check_eq("pix_tr", 32'(pix_tr), 32'(tr));
        check_eq("pix_bl", 32'(pix_bl), 32'(bl));
        check_eq("pix_br", 32'(pix_br), 32'(br));
        check_eq("frac_x", 32'(frac_x), 32'(fr));
      end
    end
  endtask

  task automatic run_reset_mid_line();
    @(negedge clk);
    src_width = 12'd64;
    dst_width = 12'd16;
    step      = 16'h1800;
    row_sel   = 1'b0;
    start     = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      start = 1'b0;
    end
    check_eq("pre_rst_valid", 32'(out_valid), 1);
    rst = 1'b1;
    @(negedge clk);
    check_reset_outputs("mid_rst");
    rst = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      check_eq("post_rst_done", 32'(done), 0);
      check_eq("post_rst_valid", 32'(out_valid), 0);
    end
    run_line(64, 16, 16'h1800, 1'b0, 1'b0);
  endtask

  initial begin
    rst       = 1'b1;
    start     = 1'b0;
    src_width = 12'd8;
    dst_width = 12'd8;
    step      = 16'h1000;
    row_sel   = 1'b0;
    key1      = 24'h111111;
    key2      = 24'h222222;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;
    @(negedge clk);

    run_line(8, 8, 16'h1000, 1'b0, 1'b0);
    run_line(4, 8, 16'h0800, 1'b0, 1'b0);
    run_line(4, 8, 16'h0800, 1'b1, 1'b0);
    run_line(8, 8, 16'h1000, 1'b0, 1'b1);
    run_reset_mid_line();
    run_line(8, 0, 16'h1000, 1'b0, 1'b0);
    run_line(4, 4, 16'hf000, 1'b0, 1'b0);
    run_line(1, 6, 16'h1234, 1'b1, 1'b0);
    run_line(4095, 300, 16'hffff, 1'b1, 1'b0);
    for (int n = 0; n < 12; n++) begin
      run_line(int'($urandom_range(1, 300)), int'($urandom_range(0, 40)), 16'($urandom),
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
